// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Recovers column/row position from a pair of "active-high" sync inputs
//   (high during visible columns/rows) and qualifies it with a lock FSM.
//
//   Ports
//     i_Clk, i_Rst_L        pixel clock, async active-low reset
//     i_HSync, i_VSync      incoming syncs, high during active cols / rows
//     o_HSync, o_VSync      syncs delayed one clock, aligned with the counts
//     o_Col_Count/Row_Count decoded position (0,0 = first active pixel)
//     o_Active              locked and inside the visible region
//     o_Locked              FSM is in LOCKED
//     o_Frame_Start         one-clock pulse when the counts load (0,0)
//     o_Frame_Count         frames accepted while locked, wraps
//     o_Err, o_Err_Count    timing-mismatch pulse and saturating total
module vga_sync_decoder #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Locked,
  output logic       o_Frame_Start,
  output logic [7:0] o_Frame_Count,
  output logic       o_Err,
  output logic [7:0] o_Err_Count
);

  localparam int TMO_CLKS = 2 * TOTAL_COLS * TOTAL_ROWS;
  localparam int TMO_W    = $clog2(TMO_CLKS + 1);

  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] COL_ACT  = 10'(ACTIVE_COLS);
  localparam logic [9:0] ROW_ACT  = 10'(ACTIVE_ROWS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CLKS - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [9:0]       col_d, row_d;
  logic             hs_edge, vs_edge, col_end, frame_end, tmo_hit;
  logic             err_d, fc_inc, active_d;

  // o_HSync/o_VSync double as the registered copies used for edge detect.
  assign hs_edge   = i_HSync & ~o_HSync;
  assign vs_edge   = i_VSync & ~o_VSync;
  assign col_end   = (o_Col_Count == COL_LAST);
  assign frame_end = col_end && (o_Row_Count == ROW_LAST);
  // A VSync edge in the same clock restarts the watchdog instead.
  assign tmo_hit   = (tmo_q == TMO_LAST) && !vs_edge;
  assign o_Locked  = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    fc_inc  = 1'b0;
    unique case (state_q)
      SEARCH: if (vs_edge) state_d = ALIGN;
      ALIGN: begin
        if (tmo_hit) state_d = SEARCH;
        else if (vs_edge) begin
          if (frame_end) begin
            state_d = LOCKED;
            fc_inc  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        // A frame_end VSync edge also satisfies the HSync check, so the
        // simultaneous case yields a single error at most.
        if (tmo_hit) state_d = SEARCH;
        else if (vs_edge && frame_end) fc_inc = 1'b1;
        else if (vs_edge || (hs_edge && !col_end)) begin
          err_d   = 1'b1;
          state_d = ALIGN;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    col_d = o_Col_Count;
    row_d = o_Row_Count;
    tmo_d = tmo_q + TMO_W'(1);
    if (state_d == SEARCH || vs_edge) begin
      col_d = '0;
      row_d = '0;
      tmo_d = '0;
    end else if (col_end) begin
      col_d = '0;
      row_d = (o_Row_Count == ROW_LAST) ? 10'd0 : o_Row_Count + 10'd1;
    end else begin
      col_d = o_Col_Count + 10'd1;
    end
    active_d = (state_d == LOCKED) && (col_d < COL_ACT) && (row_d < ROW_ACT);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= SEARCH;
      tmo_q         <= '0;
      o_HSync       <= 1'b0;
      o_VSync       <= 1'b0;
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
      o_Active      <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Frame_Count <= '0;
      o_Err         <= 1'b0;
      o_Err_Count   <= '0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      o_HSync       <= i_HSync;
      o_VSync       <= i_VSync;
      o_Col_Count   <= col_d;
      o_Row_Count   <= row_d;
      o_Active      <= active_d;
      o_Frame_Start <= vs_edge;
      o_Err         <= err_d;
      if (fc_inc) o_Frame_Count <= o_Frame_Count + 8'd1;
      if (err_d && o_Err_Count != 8'hFF) o_Err_Count <= o_Err_Count + 8'd1;
    end
  end

endmodule
